// File: rtl/ps2_tx_pkg.sv
// Shared constants, key-word field positions, FSM state and frame builder for the PS/2 device-side transmitter.
package ps2_tx_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int unsigned KEY_W        = 11;
    localparam int unsigned KEY_TGL      = 10;
    localparam int unsigned KEY_PRS      = 9;
    localparam int unsigned KEY_EXT      = 8;
    localparam int unsigned KEY_CODE_MSB = 7;

    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BIT,
        ST_GAP
    } tx_state_e;

    // Wire order, LSB first: start 0, data[0..7], odd parity, stop 1.
    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO with free-slot count, used to queue scan-code bytes ahead of the serializer.
module ps2_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   free,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign free    = CW'(DEPTH) - count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Turns hps_io key events into make/break byte sequences and clocks them out as PS/2 device frames.
module ps2_kbd_tx
    import ps2_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned GAP_BITS   = 2,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [KEY_W-1:0] ps2_key,
    output logic             ps2_kbd_clk,
    output logic             ps2_kbd_data,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GAP_CYC = GAP_BITS * 2 * CLK_DIV;
    localparam int unsigned GW      = $clog2(GAP_CYC);

    logic       key_tgl, key_prs, key_ext;
    logic [7:0] key_code;
    logic       primed, tgl_q;
    logic       event_c, accept;
    logic [1:0] need;
    logic [7:0] seq0, seq1;
    logic [1:0] pend_cnt;
    logic [7:0] pend0, pend1;

    logic             fifo_push, fifo_pop, fifo_empty;
    logic [7:0]       fifo_din, fifo_dout;
    logic [CNT_W-1:0] fifo_free;

    tx_state_e             state, state_d;
    logic [DIV_W-1:0]      cnt, cnt_d;
    logic [3:0]            bit_idx, bit_d;
    logic [GW-1:0]         gap_cnt, gap_d;
    logic [FRAME_BITS-1:0] frame, frame_d;
    logic                  clk_d, data_d;

    assign key_tgl  = ps2_key[KEY_TGL];
    assign key_prs  = ps2_key[KEY_PRS];
    assign key_ext  = ps2_key[KEY_EXT];
    assign key_code = ps2_key[KEY_CODE_MSB:0];

    assign event_c = primed && (key_tgl != tgl_q);
    assign need    = 2'd1 + {1'b0, key_ext} + {1'b0, ~key_prs};
    // Whole event fits or nothing is queued; an event overlapping a pending tail is dropped.
    assign accept  = event_c && (pend_cnt == 2'd0) && (fifo_free >= CNT_W'(need));

    // First byte of the sequence goes out at event time; the code byte is always last.
    always_comb begin
        seq0 = key_code;
        seq1 = key_code;
        if (key_ext && !key_prs) begin
            seq0 = PS2_EXT;
            seq1 = PS2_BRK;
        end else if (key_ext) begin
            seq0 = PS2_EXT;
        end else if (!key_prs) begin
            seq0 = PS2_BRK;
        end
    end

    assign fifo_push = accept || (pend_cnt != 2'd0);
    assign fifo_din  = accept ? seq0 : pend0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed   <= 1'b0;
            tgl_q    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            pend_cnt <= 2'd0;
            pend0    <= '0;
            pend1    <= '0;
        end else begin
            primed   <= 1'b1;
            tgl_q    <= key_tgl;
            overflow <= event_c && !accept;
            busy     <= (state != ST_IDLE) || !fifo_empty || (pend_cnt != 2'd0);
            if (accept) begin
                pend_cnt <= need - 2'd1;
                pend0    <= seq1;
                pend1    <= key_code;
            end else if (pend_cnt != 2'd0) begin
                pend_cnt <= pend_cnt - 2'd1;
                pend0    <= pend1;
            end
        end
    end

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .free    (fifo_free),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            frame        <= '1;
            ps2_kbd_clk  <= 1'b1;
            ps2_kbd_data <= 1'b1;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bit_idx      <= bit_d;
            gap_cnt      <= gap_d;
            frame        <= frame_d;
            ps2_kbd_clk  <= clk_d;
            ps2_kbd_data <= data_d;
        end
    end

    // GAP is one cycle short so the IDLE pop cycle completes the inter-frame idle time.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        bit_d    = bit_idx;
        gap_d    = gap_cnt;
        frame_d  = frame;
        clk_d    = ps2_kbd_clk;
        data_d   = ps2_kbd_data;
        fifo_pop = 1'b0;
        unique case (state)
            ST_IDLE: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    frame_d  = ps2_frame(fifo_dout);
                    data_d   = frame_d[0];
                    bit_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_BIT;
                end
            end
            ST_BIT: begin
                if (cnt == DIV_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (ps2_kbd_clk) begin
                        clk_d = 1'b0;
                    end else if (bit_idx == 4'(FRAME_BITS - 1)) begin
                        clk_d   = 1'b1;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        clk_d  = 1'b1;
                        bit_d  = bit_idx + 4'd1;
                        data_d = frame[bit_d];
                    end
                end else begin
                    cnt_d = cnt + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 2)) state_d = ST_IDLE;
                else                             gap_d   = gap_cnt + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench: key events queue expected bytes; a line monitor decodes PS/2 frames and checks them.
module tb_ps2_kbd_tx;

    localparam int unsigned CLK_DIV    = 16;
    localparam int unsigned GAP_BITS   = 2;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int FRAME_CYC = 22 * CLK_DIV;
    localparam int SLOT_CYC  = (22 + 2 * GAP_BITS) * CLK_DIV;
    localparam int GAP_CYC   = 2 * GAP_BITS * CLK_DIV;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        ps2_kbd_clk, ps2_kbd_data, busy, overflow;

    ps2_kbd_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_BITS   (GAP_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_key      (ps2_key),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         start_times[$];
    int         cyc = 0;
    int         frames_seen = 0;
    int         last_end = 0;
    int         busy_fall = 0;
    int         mon_nbits = 0;
    int         ovf_seen = 0;
    int         ovf_exp = 0;
    int         slots_used = 0;
    logic       tgl = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Line monitor: decodes frames on falling ps2_kbd_clk and scores them against exp_q.
    logic        in_frame = 1'b0;
    logic        prev_clk = 1'b1;
    logic        prev_busy = 1'b0;
    logic [10:0] fbits;
    int          t_start = 0;
    logic [7:0]  e;

    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            in_frame  = 1'b0;
            mon_nbits = 0;
            prev_clk  = 1'b1;
            prev_busy = 1'b0;
        end else begin
            if (!in_frame && ps2_kbd_clk && !ps2_kbd_data) begin
                in_frame  = 1'b1;
                mon_nbits = 0;
                t_start   = cyc;
                start_times.push_back(cyc);
                frames_seen++;
            end else if (in_frame) begin
                if (prev_clk && !ps2_kbd_clk && mon_nbits < 11) begin
                    fbits[mon_nbits] = ps2_kbd_data;
                    mon_nbits++;
                    if (mon_nbits == 11) begin
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_frame: got byte %0h, expected no frame", fbits[8:1]);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_byte",   32'(fbits[8:1]), 32'(e));
                            chk("frame_start",  32'(fbits[0]), 32'(0));
                            chk("frame_parity", 32'(fbits[9]), ($countones(e) % 2 == 0) ? 32'(1) : 32'(0));
                            chk("frame_stop",   32'(fbits[10]), 32'(1));
                        end
                    end
                end else if (!prev_clk && ps2_kbd_clk && mon_nbits == 11) begin
                    chk("frame_len", 32'(cyc - t_start), 32'(FRAME_CYC));
                    last_end = cyc;
                    in_frame = 1'b0;
                end
            end
            if (prev_busy && !busy) busy_fall = cyc;
            prev_clk  = ps2_kbd_clk;
            prev_busy = busy;
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n && overflow) ovf_seen++;
    end

    // Reference: a key event needs E0 (extended) + F0 (release) + code slots, all or none.
    task automatic send(input logic prs, input logic ext, input logic [7:0] code, input bit from_idle);
        int n;
        bit ok;
        n = 1 + (ext ? 1 : 0) + (prs ? 0 : 1);
        if (from_idle) slots_used = 0;
        ok = (int'(FIFO_DEPTH) - slots_used) >= n;
        @(negedge clk_sys);
        tgl     = ~tgl;
        ps2_key = {tgl, prs, ext, code};
        if (ok) begin
            if (ext)  exp_q.push_back(8'hE0);
            if (!prs) exp_q.push_back(8'hF0);
            exp_q.push_back(code);
            slots_used += from_idle ? n - 1 : n;
        end else begin
            ovf_exp++;
        end
        @(negedge clk_sys);
        chk("overflow_pulse", 32'(overflow), ok ? 32'(0) : 32'(1));
        @(negedge clk_sys);
        chk("overflow_clear", 32'(overflow), 32'(0));
        @(negedge clk_sys);
    endtask

    task automatic wait_idle(input bit gap_chk);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 12000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("idle_timeout", 32'(n < 12000), 32'(1));
        repeat (2) @(negedge clk_sys);
        if (gap_chk) chk("busy_after_stop", 32'(busy_fall - last_end), 32'(GAP_CYC));
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        repeat (5) @(negedge clk_sys);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr0;
        int n;
        reset_n = 1'b0;
        ps2_key = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_clk",  32'(ps2_kbd_clk), 32'(1));
        chk("rst_data", 32'(ps2_kbd_data), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ovf",  32'(overflow), 32'(0));
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        // Make of 0x1C from an idle line.
        send(1'b1, 1'b0, 8'h1C, 1'b1);
        wait_idle(1'b1);

        // Extended release of 0x75: three frames on a fixed slot pitch.
        start_times.delete();
        send(1'b0, 1'b1, 8'h75, 1'b1);
        wait_idle(1'b1);
        chk("ext_rel_frames", 32'(start_times.size()), 32'(3));
        if (start_times.size() == 3) begin
            chk("slot_pitch_0", 32'(start_times[1] - start_times[0]), 32'(SLOT_CYC));
            chk("slot_pitch_1", 32'(start_times[2] - start_times[1]), 32'(SLOT_CYC));
        end

        // Parity corner codes.
        send(1'b1, 1'b0, 8'h00, 1'b1);
        wait_idle(1'b1);
        send(1'b1, 1'b0, 8'hFF, 1'b1);
        wait_idle(1'b1);

        // Fill to 14 queued bytes, overflow a 3-byte event, then fill exactly with a 2-byte one.
        for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 8'(8'h10 + i), i == 0);
        send(1'b0, 1'b1, 8'h66, 1'b0);
        send(1'b0, 1'b0, 8'h22, 1'b0);
        wait_idle(1'b1);

        // Randomized bursts of key events.
        for (int b = 0; b < 12; b++) begin
            int ne;
            ne = $urandom_range(1, 3);
            for (int k = 0; k < ne; k++)
                send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), k == 0);
            wait_idle(1'b1);
        end

        // Reset during data bit 4, released with the toggle bit high.
        send(1'b1, 1'b0, 8'hA5, 1'b1);
        n = 0;
        while (mon_nbits < 5 && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("bit4_reach", 32'(n < 2000), 32'(1));
        repeat (CLK_DIV + 2) @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        tgl     = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h5A};
        exp_q.delete();
        #1;
        chk("midrst_clk",  32'(ps2_kbd_clk), 32'(1));
        chk("midrst_data", 32'(ps2_kbd_data), 32'(1));
        chk("midrst_busy", 32'(busy), 32'(0));
        repeat (3) @(negedge clk_sys);
        fr0 = frames_seen;
        reset_n = 1'b1;
        repeat (1500) @(negedge clk_sys);
        chk("no_frame_after_rst", 32'(frames_seen - fr0), 32'(0));
        chk("idle_after_rst", 32'(busy), 32'(0));
        send(1'b1, 1'b0, 8'h3A, 1'b1);
        wait_idle(1'b1);
        chk("frame_after_toggle", 32'(frames_seen - fr0), 32'(1));

        chk("overflow_count", 32'(ovf_seen), 32'(ovf_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
